// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor slice with a borrow flip-flop between bits.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_sh_nxt;
  logic [WIDTH-1:0] w_b_sh_nxt;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_brw_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_diff_nxt;
  logic             w_bout_nxt;
  logic             w_ovf_nxt;

  logic             w_d;
  logic             w_brw_slice;
  logic [WIDTH-1:0] w_sh_shifted;

  // One full-subtractor bit-slice on the current LSBs and the stored borrow.
  assign w_d          = r_a_sh[0] ^ r_b_sh[0] ^ r_brw;
  assign w_brw_slice  = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_brw);
  assign w_sh_shifted = {w_d, r_sh[WIDTH-1:1]};

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt = r_state;
    w_a_sh_nxt  = r_a_sh;
    w_b_sh_nxt  = r_b_sh;
    w_sh_nxt    = r_sh;
    w_brw_nxt   = r_brw;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_diff_nxt  = r_diff;
    w_bout_nxt  = r_bout;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_sh_nxt  = a;
          w_b_sh_nxt  = b;
          w_brw_nxt   = bin;
          w_sh_nxt    = {WIDTH{1'b0}};
          w_cnt_nxt   = {CW{1'b0}};
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_sh_nxt   = w_sh_shifted;
        w_a_sh_nxt = {1'b0, r_a_sh[WIDTH-1:1]};
        w_b_sh_nxt = {1'b0, r_b_sh[WIDTH-1:1]};
        w_brw_nxt  = w_brw_slice;
        w_cnt_nxt  = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        if (r_cnt == CW'(WIDTH - 1)) begin
          // r_brw is the borrow into the MSB on this final slice.
          w_diff_nxt  = w_sh_shifted;
          w_bout_nxt  = w_brw_slice;
          w_ovf_nxt   = r_brw ^ w_brw_slice;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a_sh  <= {WIDTH{1'b0}};
      r_b_sh  <= {WIDTH{1'b0}};
      r_sh    <= {WIDTH{1'b0}};
      r_brw   <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= {WIDTH{1'b0}};
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a_sh  <= w_a_sh_nxt;
      r_b_sh  <= w_b_sh_nxt;
      r_sh    <= w_sh_nxt;
      r_brw   <= w_brw_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_diff  <= w_diff_nxt;
      r_bout  <= w_bout_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: an arithmetic reference model
// predicts each result and its completion edge; a monitor checks DUT outputs.
module tb_serial_subtractor_ctrl;

  localparam int W = 6;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           due;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   cur_exp;
  int     checks    = 0;
  int     failures  = 0;
  int     edge_cnt  = 0;
  int     acc_edge  = -100;
  int     free_at   = 0;
  bit     seen_reset = 1'b0;
  bit     held_mode = 1'b0;
  int     held_prev = 0;
  logic [W-1:0] last_d  = '0;
  logic         last_bo = 1'b0;
  logic         last_ov = 1'b0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Plain-arithmetic reference for a - b - bin at width W.
  function automatic exp_t ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                   input logic rbin, input int due);
    exp_t e;
    int ai, bi, ci, sa, sb, r;
    ai = int'(ra);
    bi = int'(rb);
    ci = int'(rbin);
    sa = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
    sb = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
    r  = sa - sb - ci;
    e.d   = W'(ai - bi - ci);
    e.bo  = (ai < bi + ci);
    e.ov  = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    e.due = due;
    return e;
  endfunction

  // Reference model: decides acceptance from timing rules and predicts results.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (reset) begin
        sb_q.delete();
        acc_edge   = -100;
        free_at    = edge_cnt + 1;
        last_d     = '0;
        last_bo    = 1'b0;
        last_ov    = 1'b0;
        seen_reset = 1'b1;
      end else begin
        if (acc_edge >= 0 && edge_cnt == acc_edge + W) begin
          last_d  = cur_exp.d;
          last_bo = cur_exp.bo;
          last_ov = cur_exp.ov;
        end
        if (start && edge_cnt >= free_at) begin
          acc_edge = edge_cnt;
          free_at  = edge_cnt + W + 2;
          cur_exp  = ref_sub(a, b, bin, edge_cnt + W);
          sb_q.push_back(cur_exp);
        end
      end
    end
  end

  // Monitor: checks handshake every cycle and pops the scoreboard on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (seen_reset) begin
        check("busy", 32'(busy), 32'(acc_edge >= 0 && edge_cnt >= acc_edge && edge_cnt < acc_edge + W));
        check("done", 32'(done), 32'(acc_edge >= 0 && edge_cnt == acc_edge + W));
        check("diff_hold", 32'(diff), 32'(last_d));
        check("bout_hold", 32'(bout), 32'(last_bo));
        check("ovf_hold", 32'(ovf), 32'(last_ov));
        if (done === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(1), 32'(0));
          end else begin
            e = sb_q.pop_front();
            check("sb_due_edge", 32'(edge_cnt), 32'(e.due));
            check("sb_diff", 32'(diff), 32'(e.d));
            check("sb_bout", 32'(bout), 32'(e.bo));
            check("sb_ovf", 32'(ovf), 32'(e.ov));
          end
          if (held_mode) begin
            if (held_prev != 0) check("held_spacing", 32'(edge_cnt - held_prev), 32'(W + 2));
            held_prev = edge_cnt;
          end
        end
      end
    end
  end

  // Directed op with literal expectations; optional start pulse during SHIFT.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input bit disturb);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (disturb && i == 2) begin
        start = 1'b1; a = '1; b = W'($urandom);
      end else begin
        start = 1'b0; a = W'($urandom);
      end
      if (i < W) check("op_busy", 32'(busy), 32'(1));
    end
    check("op_done", 32'(done), 32'(1));
    check("op_busy_low", 32'(busy), 32'(0));
    check("op_diff", 32'(diff), 32'(ed));
    check("op_bout", 32'(bout), 32'(eb));
    check("op_ovf", 32'(ovf), 32'(eo));
    @(negedge clk);
    check("op_done_clear", 32'(done), 32'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    reset = 1'b0;

    run_op(6'b000011, 6'b000011, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
    run_op(6'b000001, 6'b000011, 1'b0, 6'b111110, 1'b1, 1'b0, 1'b0);
    run_op(6'b100000, 6'b000001, 1'b0, 6'b011111, 1'b0, 1'b1, 1'b0);
    run_op(6'b000101, 6'b000010, 1'b1, 6'b000010, 1'b0, 1'b0, 1'b0);
    run_op(6'b000011, 6'b000011, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);

    // Reset lands on the third SHIFT edge.
    @(negedge clk);
    start = 1'b1; a = 6'b010000; b = 6'b000001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_diff", 32'(diff), 32'(0));
    check("abort_bout", 32'(bout), 32'(0));
    check("abort_ovf", 32'(ovf), 32'(0));
    run_op(6'b000010, 6'b000001, 1'b0, 6'b000001, 1'b0, 1'b0, 1'b0);

    // start held high for three back-to-back operations.
    @(negedge clk);
    held_prev = 0;
    held_mode = 1'b1;
    start = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    for (int j = 0; j < 3 * (W + 2) - 1; j++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    held_mode = 1'b0;
    check("held_count_seen", 32'(held_prev != 0), 32'(1));

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
      reset = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (W + 3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Bit-serial subtractor that computes a - b - bin over WIDTH clock cycles, LSB first.
- Each cycle, one full-subtractor bit-slice (diff = x^y^c, borrow = (~x&y) | (~(x^y)&c)) processes one bit, and a borrow flip-flop carries the borrow to the next bit.
- Sits directly upstream of the combinational subtractor datapath as its sequencing stage: it replaces a WIDTH-wide ripple chain with a single bit-slice plus registers.
- Provides a start/busy/done handshake to the bench or controller above it.

Parameters:
WIDTH, 6, operand and result width in bits (legal: 2..32)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured when start is accepted
- b  input  WIDTH  subtrahend, captured when start is accepted
- bin  input  1  borrow-in, captured when start is accepted
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  result register
- bout  output  1  final borrow-out (unsigned a < b + bin)
- ovf  output  1  signed overflow: borrow into MSB XOR borrow out of MSB

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset is synchronous and active-high; reset has priority over every other input.
  - Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0. Internal shift registers, borrow flip-flop and bit counter are cleared.
- States:
  - IDLE:
    - On an edge with start=1: capture a, b and bin into a_sh, b_sh and brw. Set cnt=0 and busy=1, then go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT: on each edge:
    - d = a_sh[0]^b_sh[0]^brw.
    - brw_next = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&brw).
    - Shift d into the MSB of the accumulator r_sh.
    - Shift a_sh and b_sh right by 1.
    - cnt increments.
  - Last SHIFT edge (cnt==WIDTH-1):
    - diff <= final r_sh including d. bout <= brw_next. ovf <= brw ^ brw_next, where brw here is the borrow into the MSB.
    - busy <= 0, done <= 1, go to DONE.
  - DONE: lasts exactly one cycle. Next edge: done <= 0, go to IDLE. start is ignored in DONE.
- Latency:
  - start accepted at edge k: busy=1 after edge k.
  - done=1 and the result is valid after edge k+WIDTH. done=0 after edge k+WIDTH+1.
  - Earliest next accept is edge k+WIDTH+2.
- Boundary rules:
  - start while in SHIFT or DONE is ignored. It is not queued, and the in-flight operands are unaffected.
  - Changes on a, b or bin after capture do not affect the result.
  - diff, bout and ovf hold their last values until the next completion. They do not change during SHIFT.
  - Reset asserted mid-SHIFT aborts the operation: next cycle is IDLE with all outputs 0, and no done pulse.
  - start held high continuously: a new operation is accepted every WIDTH+2 cycles.
  - Arithmetic is modulo 2^WIDTH. bout equals the unsigned borrow. ovf uses two's-complement interpretation.

Test Plan:
1. WIDTH=6, a=000011, b=000011, bin=0, start pulse at edge k -> busy during edges k+1..k+6. Then done=1 for exactly one cycle after edge k+6, with diff=000000, bout=0, ovf=0.
2. a=000001, b=000011, bin=0 -> diff=111110, bout=1, ovf=0.
3. a=100000, b=000001, bin=0 (-32 - 1) -> diff=011111, bout=0, ovf=1. Also a=000101, b=000010, bin=1 -> diff=000010, bout=0, ovf=0.
4. During SHIFT of op 1: pulse start again with a=111111 and change a/b -> result still diff=000000. Exactly one done pulse; busy never re-asserts until after DONE.
5. Reset asserted at the third SHIFT edge of a=010000, b=000001 -> next cycle busy=0, done=0, diff=0, bout=0, ovf=0, state IDLE. A following start with a=000010, b=000001 completes normally with diff=000001.
6. start held high continuously for 3 operations -> done pulses spaced exactly WIDTH+2=8 cycles apart, and each result matches a-b-bin mod 64.
